// File: rtl/masked_sram_1r1w.sv
// Generic 1R1W SRAM model: per-lane write masks, 1..4 cycle read latency,
// selectable read-during-write order, and a zeroing sweep after every reset.
module masked_sram_1r1w #(
    parameter  int DEPTH        = 64,
    parameter  int WIDTH        = 184,
    parameter  int MASK_GRAN    = 23,
    parameter  int READ_LATENCY = 1,
    parameter  int BYPASS       = 1,
    localparam int AW           = (DEPTH > 2) ? $clog2(DEPTH) : 1,
    localparam int MW           = WIDTH / MASK_GRAN
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [AW-1:0]    R0_addr,
    input  logic             R0_en,
    output logic [WIDTH-1:0] R0_data,
    output logic             R0_valid,
    input  logic [AW-1:0]    W0_addr,
    input  logic             W0_en,
    input  logic [WIDTH-1:0] W0_data,
    input  logic [MW-1:0]    W0_mask,
    output logic             init_done
);

    if (WIDTH % MASK_GRAN != 0) begin : g_bad_gran
        $error("masked_sram_1r1w: WIDTH must be a multiple of MASK_GRAN");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
        $error("masked_sram_1r1w: READ_LATENCY must be 1..4");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("masked_sram_1r1w: DEPTH must be >= 2");
    end

    typedef enum logic {S_INIT, S_READY} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            init_done_q, init_done_d;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             ready, wr_fire, rd_fire, w_in, r_in;
    logic [AW-1:0]    w_idx, r_idx;
    logic [WIDTH-1:0] w_old, w_new, rd_row;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    logic [READ_LATENCY:1] vld_pipe_q, vld_pipe_d;
    logic [WIDTH-1:0]      dat_pipe_q [READ_LATENCY:1];
    logic [WIDTH-1:0]      dat_pipe_d [READ_LATENCY:1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        if (state_q == S_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(DEPTH - 1)) begin
                state_d     = S_READY;
                init_done_d = 1'b1;
                cnt_d       = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    // Out-of-range addresses are redirected to row 0 for the array lookup
    // only; the in-range flags keep them from writing or returning data.
    always_comb begin
        ready   = (state_q == S_READY);
        w_in    = (32'(W0_addr) < DEPTH);
        r_in    = (32'(R0_addr) < DEPTH);
        w_idx   = w_in ? W0_addr : '0;
        r_idx   = r_in ? R0_addr : '0;
        wr_fire = ready && W0_en && w_in;
        rd_fire = ready && R0_en;

        w_old = mem_q[w_idx];
        w_new = w_old;
        for (int i = 0; i < MW; i++) begin
            if (W0_mask[i]) w_new[i*MASK_GRAN +: MASK_GRAN] = W0_data[i*MASK_GRAN +: MASK_GRAN];
        end

        rd_row = '0;
        if (r_in) begin
            if (BYPASS != 0 && wr_fire && W0_addr == R0_addr) rd_row = w_new;
            else                                              rd_row = mem_q[r_idx];
        end

        mem_we    = wr_fire || (state_q == S_INIT);
        mem_waddr = (state_q == S_INIT) ? cnt_q : W0_addr;
        mem_wdata = (state_q == S_INIT) ? '0 : w_new;
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    // Each stage only advances when its input is valid, so the output stage
    // holds the last returned row between strobes.
    always_comb begin
        vld_pipe_d    = '0;
        dat_pipe_d    = dat_pipe_q;
        vld_pipe_d[1] = rd_fire;
        if (rd_fire) dat_pipe_d[1] = rd_row;
        for (int k = 2; k <= READ_LATENCY; k++) begin
            vld_pipe_d[k] = vld_pipe_q[k-1];
            if (vld_pipe_q[k-1]) dat_pipe_d[k] = dat_pipe_q[k-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe_q <= '0;
            for (int k = 1; k <= READ_LATENCY; k++) dat_pipe_q[k] <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            dat_pipe_q <= dat_pipe_d;
        end
    end

    assign R0_valid  = vld_pipe_q[READ_LATENCY];
    assign R0_data   = dat_pipe_q[READ_LATENCY];
    assign init_done = init_done_q;

endmodule

// File: tb/tb_masked_sram_1r1w.sv
// Drives two differently configured memories with one shared stimulus stream
// and compares both against a per-edge reference model with latency queues.
module tb_masked_sram_1r1w;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic [5:0]   r_addr, w_addr;
    logic         r_en, w_en;
    logic [183:0] w_data;
    logic [7:0]   w_mask;
    logic [183:0] rd0, rd1;
    logic         rv0, rv1, done0, done1;

    always #5 clock = ~clock;

    masked_sram_1r1w #(.DEPTH(64), .WIDTH(184), .MASK_GRAN(23), .READ_LATENCY(1), .BYPASS(1)) dut0 (
        .clock(clock), .reset_n(reset_n),
        .R0_addr(r_addr), .R0_en(r_en), .R0_data(rd0), .R0_valid(rv0),
        .W0_addr(w_addr), .W0_en(w_en), .W0_data(w_data), .W0_mask(w_mask),
        .init_done(done0)
    );

    masked_sram_1r1w #(.DEPTH(48), .WIDTH(184), .MASK_GRAN(23), .READ_LATENCY(3), .BYPASS(0)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .R0_addr(r_addr), .R0_en(r_en), .R0_data(rd1), .R0_valid(rv1),
        .W0_addr(w_addr), .W0_en(w_en), .W0_data(w_data), .W0_mask(w_mask),
        .init_done(done1)
    );

    typedef struct {
        int           due;
        logic [183:0] d;
    } pend_t;

    int dep_c [2] = '{64, 48};
    int lat_c [2] = '{1, 3};
    int byp_c [2] = '{1, 0};

    logic [183:0] m [2][64];
    pend_t        q0[$];
    pend_t        q1[$];
    int           ecnt;
    logic         exp_v [2];
    logic [183:0] exp_d [2];
    logic         exp_done [2];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [183:0] obs, input logic [183:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ecnt = 0;
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            exp_v[d] = 1'b0;
            exp_d[d] = '0;
            exp_done[d] = 1'b0;
            for (int a = 0; a < 64; a++) m[d][a] = '0;
        end
    endtask

    // One rising edge of behaviour: the memory is ready once DEPTH edges have
    // passed since reset; a read returns the row as it stands before the
    // write (read-first) or after it (write-first).
    task automatic model_edge();
        pend_t p;
        if (!reset_n) return;
        ecnt++;
        for (int d = 0; d < 2; d++) begin
            logic         rdy, do_rd;
            logic [183:0] rd;
            rdy   = (ecnt - 1) >= dep_c[d];
            do_rd = rdy && r_en;
            rd    = '0;
            if (do_rd && byp_c[d] == 0 && r_addr < dep_c[d]) rd = m[d][r_addr];
            if (rdy && w_en && w_addr < dep_c[d])
                for (int i = 0; i < 8; i++)
                    if (w_mask[i]) m[d][w_addr][i*23 +: 23] = w_data[i*23 +: 23];
            if (do_rd && byp_c[d] == 1 && r_addr < dep_c[d]) rd = m[d][r_addr];
            if (do_rd) begin
                p.due = ecnt + lat_c[d] - 1;
                p.d   = rd;
                if (d == 0) q0.push_back(p);
                else        q1.push_back(p);
            end
            exp_v[d] = 1'b0;
            if (d == 0 && q0.size() > 0 && q0[0].due == ecnt) begin
                exp_v[0] = 1'b1;
                exp_d[0] = q0[0].d;
                void'(q0.pop_front());
            end
            if (d == 1 && q1.size() > 0 && q1[0].due == ecnt) begin
                exp_v[1] = 1'b1;
                exp_d[1] = q1[0].d;
                void'(q1.pop_front());
            end
            exp_done[d] = (ecnt >= dep_c[d]);
        end
    endtask

    task automatic check_all();
        chk("valid0", {183'd0, rv0}, {183'd0, exp_v[0]});
        chk("data0", rd0, exp_d[0]);
        chk("done0", {183'd0, done0}, {183'd0, exp_done[0]});
        chk("valid1", {183'd0, rv1}, {183'd0, exp_v[1]});
        chk("data1", rd1, exp_d[1]);
        chk("done1", {183'd0, done1}, {183'd0, exp_done[1]});
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
    endtask

    initial begin
        logic [183:0] ones, a5, m81;
        logic [191:0] rnd;
        ones = '1;
        a5   = {23{8'hA5}};
        m81  = '0;
        m81[22:0]    = '1;
        m81[183:161] = '1;

        r_en = 0; r_addr = 0; w_en = 0; w_addr = 0; w_data = '0; w_mask = '0;
        #2 do_reset();
        tick(); tick();
        reset_n = 1'b1;

        // INIT with both request lines held high; dut0 must ignore all of it
        r_en = 1; r_addr = 5; w_en = 1; w_addr = 5; w_data = ones; w_mask = 8'hFF;
        repeat (64) tick();
        w_en = 0;
        tick();
        chk("init_rd5_valid", {183'd0, rv0}, 184'd1);
        chk("init_rd5_data", rd0, '0);

        // masked write, read back next cycle
        r_en = 0; w_en = 1; w_addr = 3; w_data = ones; w_mask = 8'h81;
        tick();
        w_en = 0; r_en = 1; r_addr = 3;
        tick();
        chk("mask81_dut0", rd0, m81);
        r_en = 0;
        tick();
        chk("pulse_dut0", {183'd0, rv0}, '0);
        tick();
        chk("mask81_dut1", rd1, m81);

        // same-edge write and read of row 7
        w_en = 1; w_addr = 7; w_data = a5; w_mask = 8'hFF; r_en = 1; r_addr = 7;
        tick();
        chk("bypass_dut0", rd0, a5);
        w_en = 0;
        tick();
        chk("next_rd7_dut0", rd0, a5);
        r_en = 0;
        tick();
        chk("readfirst_dut1", rd1, '0);
        tick();
        chk("next_rd7_dut1", rd1, a5);

        // back-to-back pipelined reads
        w_en = 1; w_mask = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            w_addr = 6'(i); w_data = 184'(i + 1);
            tick();
        end
        w_en = 0;
        for (int i = 0; i < 3; i++) begin
            r_en = 1; r_addr = 6'(i);
            tick();
        end
        r_en = 0;
        repeat (4) tick();
        chk("hold3_dut1", rd1, 184'd3);

        // rows beyond DEPTH=48
        w_en = 1; w_addr = 50; w_data = ones; w_mask = 8'hFF;
        tick();
        w_en = 0; r_en = 1; r_addr = 50;
        tick();
        r_addr = 47;
        tick();
        r_en = 0;
        repeat (3) tick();

        // reset with reads in flight
        r_en = 1; r_addr = 3;
        tick(); tick();
        do_reset();
        tick(); tick();
        reset_n = 1'b1;
        repeat (64) tick();
        tick();
        chk("rezero_dut0", rd0, '0);

        // randomized traffic with a bias towards colliding addresses
        repeat (600) begin
            for (int k = 0; k < 6; k++) rnd[k*32 +: 32] = $urandom;
            w_data = rnd[183:0];
            w_mask = 8'($urandom);
            w_en   = 1'($urandom_range(0, 1));
            r_en   = 1'($urandom_range(0, 1));
            w_addr = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 9));
            r_addr = ($urandom_range(0, 2) == 0) ? w_addr
                   : (($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 9)));
            tick();
        end
        r_en = 0; w_en = 0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/masked_sram_1r1w.md
# masked_sram_1r1w

Parametrised single-clock 1-read/1-write memory with per-lane write masks, configurable read latency, selectable read-during-write behaviour and a hardware zero-initialisation sequence after reset. It is the generic behavioural replacement for fixed-geometry mock SRAM macros such as tag and data arrays. It lets one model cover every array shape in flow and simulation tests, with deterministic contents from reset.

## Interface
- DEPTH, 64, number of rows; any value >= 2, not restricted to powers of two.
- WIDTH, 184, row width in bits.
- MASK_GRAN, 23, bits per mask lane; WIDTH % MASK_GRAN == 0 is required, and elaboration fails otherwise.
- READ_LATENCY, 1, cycles from read request to data; legal range 1..4.
- BYPASS, 1, 1 = write-first (a same-cycle write is visible to the read), 0 = read-first.
- Derived: AW = max(1, clog2(DEPTH)); MW = WIDTH / MASK_GRAN.

Ports:
- clock  in  1  sole clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- R0_addr  in  AW  read address.
- R0_en  in  1  read request.
- R0_data  out  WIDTH  read data.
- R0_valid  out  1  one-cycle strobe marking R0_data as fresh.
- W0_addr  in  AW  write address.
- W0_en  in  1  write request.
- W0_data  in  WIDTH  write data.
- W0_mask  in  MW  lane enables; lane i covers bits [i*MASK_GRAN +: MASK_GRAN].
- init_done  out  1  high once zero-initialisation has completed.

## Operation
- Reset (reset_n low, takes effect asynchronously):
  - FSM goes to INIT and the row counter clears to 0.
  - init_done=0, R0_valid=0, R0_data=0.
  - All read pipeline stages are cleared.
- INIT state:
  - Each edge writes all-zero to row[counter], then increments the counter.
  - On the edge that writes row DEPTH-1, the FSM moves to READY.
  - R0_en and W0_en are ignored while in INIT: no write, no R0_valid.
- READY state: terminal until the next reset. init_done=1.
- Write (READY, W0_en=1, W0_addr < DEPTH): for every lane i with W0_mask[i]=1, that lane of row[W0_addr] takes W0_data. Lanes with mask 0 keep their value.
- Write with W0_addr >= DEPTH is dropped silently.
- Read (READY, R0_en=1): the row is sampled on the request edge.
  - If BYPASS=1 and a write to the same address occurs on the same edge, the returned row is the masked merge: new lanes where the mask is set, old lanes elsewhere.
  - If BYPASS=0, the returned row is the pre-write contents.
  - R0_addr >= DEPTH returns all-zero and still produces R0_valid.
- Writes after the sampling edge never alter data already in the read pipeline.
- R0_data holds the last valid value while R0_valid=0. It is never X.
- Back-to-back reads are fully pipelined, one per cycle, and return in order.

## Timing
- Read: with R0_en high at edge t, R0_valid=1 and R0_data update after edge t+READ_LATENCY-1 (visible in cycle t+READ_LATENCY). The strobe lasts exactly one cycle per request.
- Write-to-read: a write at edge t is visible to a read sampled at edge t+1. With BYPASS=1 it is also visible to a read sampled at edge t.
- Init: init_done rises after exactly DEPTH rising edges with reset_n high. Requests issued on the edge that completes INIT are ignored.
- Reset mid-operation:
  - In-flight reads are discarded and R0_valid drops immediately (asynchronously).
  - Memory is fully re-zeroed by a new INIT sequence.

## Test plan
- Release reset (defaults) -> init_done=0 for exactly 64 edges, then 1. A read of address 5 returns 0 with R0_valid=1 one cycle later, and R0_valid=0 throughout INIT even with R0_en held high.
- Write addr 3, data all-ones, mask 8'h81; read addr 3 next cycle -> bits 22:0 and 183:161 are 1, all other bits 0, R0_valid a single-cycle pulse.
- Same edge: write addr 7 with data 184'hA5...A5, mask 8'hFF, plus read addr 7.
  - BYPASS=1 -> read returns the A5 pattern.
  - BYPASS=0 -> read returns 0.
  - A read of addr 7 on the next edge returns A5 in both cases.
- READ_LATENCY=3: preload rows 0,1,2 with 1,2,3, then read addresses 0,1,2 on consecutive edges -> R0_valid high three cycles later for three consecutive cycles with data 1,2,3. R0_data holds 3 afterwards.
- READ_LATENCY=2: pull reset_n low while two reads are in flight -> R0_valid=0 and init_done=0 immediately, no stale strobe after release, and previously written rows read 0 after re-INIT.
- DEPTH=48, AW=6: write addr 50 with mask all-ones, then read addrs 50 and 47 -> both return 0 with R0_valid=1, and no row is corrupted.
